// File: rtl/popcount_stream_accumulator.sv
// Re-serialises per-cycle popcounts into a single stochastic bitstream.
// Each accepted popcount feeds a residue accumulator; one output one is emitted per SCALE input ones.
module popcount_stream_accumulator #(
    parameter int SUM_WIDTH = 4,
    parameter int ACC_WIDTH = 8,
    parameter int SCALE     = 1
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic [SUM_WIDTH-1:0] sum_in,
    input  logic                 sum_valid,
    output logic                 sum_ready,
    input  logic                 flush,
    input  logic                 clear,
    output logic                 bit_out,
    output logic                 bit_valid,
    output logic [ACC_WIDTH-1:0] residue,
    output logic                 overflow,
    output logic                 drain_done
);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    // One extra bit of headroom so acc + sum_in can never wrap before the saturation test.
    localparam logic [ACC_WIDTH:0]   SCALE_EXT = (ACC_WIDTH+1)'(SCALE);
    localparam logic [ACC_WIDTH:0]   ACC_MAX   = {1'b0, {ACC_WIDTH{1'b1}}};
    localparam logic [ACC_WIDTH-1:0] SCALE_ACC = ACC_WIDTH'(SCALE);

    logic [0:0]           state_reg, state_next;
    logic [ACC_WIDTH-1:0] acc_reg, acc_next;
    logic                 bit_out_reg, bit_out_next;
    logic                 bit_valid_reg, bit_valid_next;
    logic                 overflow_reg, overflow_next;
    logic                 drain_done_reg, drain_done_next;
    logic [ACC_WIDTH:0]   sum_t;

    assign sum_ready  = (state_reg == ST_RUN);
    assign bit_out    = bit_out_reg;
    assign bit_valid  = bit_valid_reg;
    assign residue    = acc_reg;
    assign overflow   = overflow_reg;
    assign drain_done = drain_done_reg;

    always_comb begin
        state_next      = state_reg;
        acc_next        = acc_reg;
        bit_out_next    = 1'b0;
        bit_valid_next  = 1'b0;
        overflow_next   = overflow_reg;
        drain_done_next = 1'b0;
        sum_t           = '0;

        // clear wins over everything, including a transfer that sum_ready would otherwise accept.
        if (clear) begin
            acc_next      = '0;
            overflow_next = 1'b0;
            state_next    = ST_RUN;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (sum_valid) begin
                        sum_t = {1'b0, acc_reg} + (ACC_WIDTH+1)'(sum_in);
                        if (sum_t >= SCALE_EXT) begin
                            bit_out_next = 1'b1;
                            sum_t        = sum_t - SCALE_EXT;
                        end
                        if (sum_t > ACC_MAX) begin
                            acc_next      = ACC_MAX[ACC_WIDTH-1:0];
                            overflow_next = 1'b1;
                        end else begin
                            acc_next = sum_t[ACC_WIDTH-1:0];
                        end
                        bit_valid_next = 1'b1;
                    end
                    if (flush) begin
                        state_next = ST_DRAIN;
                    end
                end
                default: begin
                    if ({1'b0, acc_reg} >= SCALE_EXT) begin
                        bit_out_next   = 1'b1;
                        bit_valid_next = 1'b1;
                        acc_next       = acc_reg - SCALE_ACC;
                    end else begin
                        drain_done_next = 1'b1;
                        state_next      = ST_RUN;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg      <= ST_RUN;
            acc_reg        <= '0;
            bit_out_reg    <= 1'b0;
            bit_valid_reg  <= 1'b0;
            overflow_reg   <= 1'b0;
            drain_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            acc_reg        <= acc_next;
            bit_out_reg    <= bit_out_next;
            bit_valid_reg  <= bit_valid_next;
            overflow_reg   <= overflow_next;
            drain_done_reg <= drain_done_next;
        end
    end

endmodule
